// File: rtl/jtframe_objdma.sv
// jtframe_objdma
// Copies LEN words of object RAM into a destination (sprite) buffer while
// holding the CPU off the bus. A rising edge on dma_go requests the bus;
// once granted, one word moves per cen until the transfer ends and the bus
// is handed back.
//
// Parameters
//   AW        source/destination word address width
//   DW        data width
//   LEN       words per transfer (1..2^AW)
//   SRC_BASE  first source address
//   DST_BASE  first destination address
//
// Ports
//   clk, rst       system clock, synchronous active-high reset
//   cen            clock enable; state only advances when it is high
//   dma_go         transfer request (rising-edge sensitive)
//   busrq/busak_n  CPU bus request (high) / bus grant (low)
//   src_addr/data  source RAM read port; data arrives one cen after address
//   dst_addr/data  destination buffer write port, dst_we write strobe
//   busy           high whenever the engine is not idle
//   dst_bank       destination buffer bank select
//
// Optional feature
//   JTFRAME_OBJDMA_DBLBUF_EN  when defined, dst_bank flips at the end of
//   each completed transfer; otherwise dst_bank is tied to 0.

module jtframe_objdma #(
    parameter int AW       = 12,
    parameter int DW       = 8,
    parameter int LEN      = 512,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          dma_go,
    output logic          busrq,
    input  logic          busak_n,
    output logic [AW-1:0] src_addr,
    input  logic [DW-1:0] src_data,
    output logic [AW-1:0] dst_addr,
    output logic [DW-1:0] dst_data,
    output logic          dst_we,
    output logic          busy,
    output logic          dst_bank
);

    localparam int            CW    = $clog2(LEN + 1);
    localparam logic [CW-1:0] LAST  = CW'(LEN - 1);
    localparam logic [AW-1:0] SRC_B = AW'(SRC_BASE);
    localparam logic [AW-1:0] DST_B = AW'(DST_BASE);

    typedef enum logic [2:0] {IDLE, REQ, COPY, FLUSH, REL} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          go_hist_q, go_hist_d;
    logic          pending_q, pending_d;
    logic          busrq_q, busrq_d;
    logic [AW-1:0] dst_addr_q, dst_addr_d;
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          use_hold_q, use_hold_d;

    logic go;
    logic granted;
    logic wr_now;

    assign go      = dma_go & ~go_hist_q;
    assign granted = ~busak_n;

    // A write happens when a word read on the previous cen is waiting and
    // the bus is still ours. Reset blocks it so an aborted transfer never
    // commits a word in the reset cycle.
    assign wr_now = cen & ~rst & granted & rd_valid_q &
                    ((state_q == COPY) || (state_q == FLUSH));

    // cnt counts words issued to the source RAM; rd_valid marks a read in
    // flight. If the bus is taken away while a word is in flight, that word
    // is parked in hold_q because the RAM output will move on to the next
    // address during the stall.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        go_hist_d  = go_hist_q;
        pending_d  = pending_q;
        busrq_d    = busrq_q;
        dst_addr_d = dst_addr_q;
        rd_valid_d = rd_valid_q;
        hold_d     = hold_q;
        use_hold_d = use_hold_q;
        if (cen) begin
            go_hist_d = dma_go;
            case (state_q)
                IDLE: begin
                    if (go || pending_q) begin
                        state_d    = REQ;
                        busrq_d    = 1'b1;
                        pending_d  = 1'b0;
                        cnt_d      = '0;
                        rd_valid_d = 1'b0;
                        use_hold_d = 1'b0;
                    end
                end
                REQ: begin
                    if (granted) state_d = COPY;
                end
                COPY, FLUSH: begin
                    if (granted) begin
                        use_hold_d = 1'b0;
                        if (state_q == COPY) begin
                            cnt_d      = cnt_q + CW'(1);
                            dst_addr_d = DST_B + AW'(cnt_q);
                            rd_valid_d = 1'b1;
                            if (cnt_q == LAST) state_d = FLUSH;
                        end else begin
                            rd_valid_d = 1'b0;
                            busrq_d    = 1'b0;
                            state_d    = REL;
                        end
                    end else if (rd_valid_q && !use_hold_q) begin
                        hold_d     = src_data;
                        use_hold_d = 1'b1;
                    end
                end
                REL: begin
                    if (!granted) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            // Requests while busy collapse into a single queued transfer.
            if (go && (state_q != IDLE)) pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            go_hist_q  <= 1'b0;
            pending_q  <= 1'b0;
            busrq_q    <= 1'b0;
            dst_addr_q <= DST_B;
            rd_valid_q <= 1'b0;
            hold_q     <= '0;
            use_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            go_hist_q  <= go_hist_d;
            pending_q  <= pending_d;
            busrq_q    <= busrq_d;
            dst_addr_q <= dst_addr_d;
            rd_valid_q <= rd_valid_d;
            hold_q     <= hold_d;
            use_hold_q <= use_hold_d;
        end
    end

    assign busrq    = busrq_q;
    assign busy     = (state_q != IDLE);
    assign src_addr = SRC_B + AW'(cnt_q);
    assign dst_addr = dst_addr_q;
    assign dst_we   = wr_now;
    assign dst_data = wr_now ? (use_hold_q ? hold_q : src_data) : '0;

`ifdef JTFRAME_OBJDMA_DBLBUF_EN
    logic bank_q, bank_d;

    // Flip banks as the last word lands so the video side sees the
    // freshly completed buffer.
    always_comb begin
        bank_d = bank_q;
        if (cen && (state_q == FLUSH) && granted) bank_d = ~bank_q;
    end

    always_ff @(posedge clk) begin
        if (rst) bank_q <= 1'b0;
        else     bank_q <= bank_d;
    end

    assign dst_bank = bank_q;
`else
    assign dst_bank = 1'b0;
`endif

endmodule

// File: tb/tb_jtframe_objdma.sv
// Directed bench for jtframe_objdma: LEN=4 transfers from a source window
// that wraps at the top of the address space (0xFFE..0x001) into a buffer
// at 0x010. The source RAM returns addr[7:0]+1, so every transfer writes
// 0xFF, 0x00, 0x01, 0x02.

module tb_jtframe_objdma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic        dma_go = 1'b0;
    logic        busrq;
    logic        busak_n = 1'b1;
    logic [11:0] src_addr;
    logic [7:0]  src_data = 8'h00;
    logic [11:0] dst_addr;
    logic [7:0]  dst_data;
    logic        dst_we;
    logic        busy;
    logic        dst_bank;

    int compared = 0;
    int mismatched = 0;

    int   cen_div = 1;
    int   cen_phase = 0;
    logic b1 = 1'b0;
    logic b2 = 1'b0;
    logic force_release = 1'b0;

    logic [11:0] log_addr [64];
    logic [7:0]  log_data [64];
    int wr_cnt = 0;
    int we_bad_cen = 0;
    int we_bad_grant = 0;
    int rq_rises = 0;
    logic prev_busrq = 1'b0;

    logic [7:0] exp_data [4] = '{8'hFF, 8'h00, 8'h01, 8'h02};

`ifdef JTFRAME_OBJDMA_DBLBUF_EN
    localparam logic BANK_EN = 1'b1;
`else
    localparam logic BANK_EN = 1'b0;
`endif

    jtframe_objdma #(
        .AW(12), .DW(8), .LEN(4), .SRC_BASE(12'hFFE), .DST_BASE(12'h010)
    ) dut (
        .clk(clk), .rst(rst), .cen(cen), .dma_go(dma_go),
        .busrq(busrq), .busak_n(busak_n),
        .src_addr(src_addr), .src_data(src_data),
        .dst_addr(dst_addr), .dst_data(dst_data), .dst_we(dst_we),
        .busy(busy), .dst_bank(dst_bank)
    );

    always #5 clk = ~clk;

    // Environment on the falling edge: clock-enable divider and a CPU that
    // grants the bus two clocks after busrq changes, unless forced to
    // release it.
    always @(negedge clk) begin
        cen_phase = (cen_phase + 1 >= cen_div) ? 0 : cen_phase + 1;
        cen = (cen_phase == 0);
        b2 = b1;
        b1 = busrq;
        busak_n = force_release ? 1'b1 : ~b2;
    end

    // Source RAM: synchronous read, advancing only on cen.
    always @(posedge clk) begin
        if (cen) src_data <= src_addr[7:0] + 8'd1;
    end

    // Destination buffer log plus write-protocol and busrq-rise monitors.
    always @(posedge clk) begin
        prev_busrq <= busrq;
        if (busrq && !prev_busrq) rq_rises <= rq_rises + 1;
        if (dst_we) begin
            log_addr[wr_cnt % 64] <= dst_addr;
            log_data[wr_cnt % 64] <= dst_data;
            wr_cnt <= wr_cnt + 1;
            if (!cen)   we_bad_cen   <= we_bad_cen + 1;
            if (busak_n) we_bad_grant <= we_bad_grant + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int hold);
        @(negedge clk);
        #1;
        dma_go = 1'b1;
        stepClk(hold);
        dma_go = 1'b0;
    endtask

    task automatic waitGrant(input int budget);
        int n = 0;
        while (busak_n !== 1'b0 && n < budget) begin
            stepClk(1);
            n++;
        end
        checkOutput("grant_timeout", 32'(n >= budget), 32'd0);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            stepClk(1);
            n++;
        end
        checkOutput("idle_timeout", 32'(n >= budget), 32'd0);
    endtask

    task automatic checkWrites(input string tag, input int base);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), log_addr[(base + i) % 64], 32'h10 + i);
            checkOutput($sformatf("%s_data%0d", tag, i), log_data[(base + i) % 64], exp_data[i]);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int n;
        int rises0;

        // Reset values
        stepClk(3);
        checkOutput("rst_busrq", busrq, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_we", dst_we, 0);
        checkOutput("rst_src", src_addr, 12'hFFE);
        checkOutput("rst_dst", dst_addr, 12'h010);
        checkOutput("rst_data", dst_data, 0);
        checkOutput("rst_bank", dst_bank, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Basic transfer with wrapping source addresses
        base = wr_cnt;
        applyStimulus(1);
        waitGrant(20);
        checkOutput("src0", src_addr, 12'hFFE);
        stepClk(1);
        checkOutput("src1", src_addr, 12'hFFF);
        stepClk(1);
        checkOutput("src2", src_addr, 12'h000);
        stepClk(1);
        checkOutput("src3", src_addr, 12'h001);
        n = 3;
        while (busrq !== 1'b0 && n < 20) begin
            stepClk(1);
            n++;
        end
        checkOutput("grant_to_release", n, 5);
        waitIdle(20);
        checkOutput("t1_count", wr_cnt - base, 4);
        checkWrites("t1", base);

        // Two requests during a transfer queue exactly one more
        base = wr_cnt;
        rises0 = rq_rises;
        applyStimulus(1);
        waitGrant(20);
        applyStimulus(1);
        stepClk(1);
        applyStimulus(1);
        waitIdle(30);
        n = 0;
        while (busy === 1'b0 && n < 20) begin
            stepClk(1);
            n++;
        end
        checkOutput("idle_gap", n, 1);
        waitIdle(30);
        stepClk(10);
        checkOutput("pend_busy", busy, 0);
        checkOutput("pend_rises", rq_rises - rises0, 2);
        checkOutput("pend_count", wr_cnt - base, 8);
        checkWrites("pend2", base + 4);

        // Bus taken away for three cycles mid-copy
        base = wr_cnt;
        applyStimulus(1);
        waitGrant(20);
        stepClk(2);
        force_release = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stepClk(1);
            checkOutput($sformatf("stall_we%0d", i), dst_we, 0);
        end
        force_release = 1'b0;
        waitIdle(30);
        checkOutput("stall_grant_we", we_bad_grant, 0);
        checkOutput("stall_count", wr_cnt - base, 4);
        checkWrites("stall", base);

        // Reset after two of four words, then a clean restart
        base = wr_cnt;
        applyStimulus(1);
        waitGrant(20);
        stepClk(3);
        rst = 1'b1;
        #1;
        checkOutput("rstmid_we_now", dst_we, 0);
        stepClk(1);
        checkOutput("rstmid_busrq", busrq, 0);
        checkOutput("rstmid_we", dst_we, 0);
        checkOutput("rstmid_busy", busy, 0);
        checkOutput("rstmid_src", src_addr, 12'hFFE);
        checkOutput("rstmid_count", wr_cnt - base, 2);
        @(negedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        while (busak_n !== 1'b1 && n < 20) begin
            stepClk(1);
            n++;
        end
        checkOutput("release_timeout", 32'(n >= 20), 0);
        base = wr_cnt;
        applyStimulus(1);
        waitIdle(30);
        checkOutput("restart_count", wr_cnt - base, 4);
        checkWrites("restart", base);

        // cen on every third clock, two transfers, bank behaviour
        @(negedge clk);
        #1;
        cen_div = 3;
        rst = 1'b1;
        stepClk(2);
        rst = 1'b0;
        checkOutput("cen_bank0", dst_bank, 0);
        base = wr_cnt;
        applyStimulus(3);
        waitIdle(200);
        checkOutput("cen_bank1", dst_bank, BANK_EN);
        applyStimulus(3);
        waitIdle(200);
        checkOutput("cen_bank2", dst_bank, 0);
        checkOutput("cen_count", wr_cnt - base, 8);
        checkOutput("cen_we_nocen", we_bad_cen, 0);
        checkWrites("cen_a", base);
        checkWrites("cen_b", base + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/jtframe_objdma.md
JTFRAME_OBJDMA -- requirements
Module: jtframe_objdma

Interface
REQ-001 SHALL have parameter AW, default 12, width of source and destination word addresses.
REQ-002 SHALL have parameter DW, default 8, data word width.
REQ-003 SHALL have parameter LEN, default 512, words per transfer, range 1..2^AW.
REQ-004 SHALL have parameter SRC_BASE, default 0, first source address.
REQ-005 SHALL have parameter DST_BASE, default 0, first destination address.
REQ-006 SHALL have ports: clk in 1 system clock; rst in 1 reset (one clock; reset synchronous, active-high).
REQ-007 SHALL have port cen, in, 1, clock enable; all state advances only on clk edges with cen=1, except reset.
REQ-008 SHALL have port dma_go, in, 1, transfer request, rising-edge sensitive.
REQ-009 SHALL have ports busrq out 1 (CPU bus request, active high) and busak_n in 1 (bus grant, active low).
REQ-010 SHALL have ports src_addr out AW and src_data in DW; source RAM read, data valid one cen after address.
REQ-011 SHALL have ports dst_addr out AW, dst_data out DW, dst_we out 1; destination buffer write.
REQ-012 SHALL have ports busy out 1 (any state other than IDLE) and dst_bank out 1 (destination buffer bank).

Function
REQ-013 SHALL implement states IDLE, REQ, COPY, FLUSH, REL.
REQ-014 SHALL register dma_go every cen and detect a rising edge as go=1 when dma_go=1 and previous sample=0.
REQ-015 IDLE: on go, or when pending=1, SHALL enter REQ, assert busrq, clear pending, and load counter to 0.
REQ-016 REQ: SHALL hold busrq=1; on the first cen with busak_n=0 SHALL enter COPY.
REQ-017 COPY: each cen SHALL drive src_addr = SRC_BASE + cnt, modulo 2^AW, and increment cnt.
REQ-018 On each cen after the first COPY cen, SHALL write dst_data = src_data at dst_addr = DST_BASE + (cnt-1), modulo 2^AW, with dst_we=1 for exactly that cen.
REQ-019 Throughput SHALL be one word per cen; a LEN-word transfer SHALL take LEN+1 cen cycles from COPY entry to the last write.
REQ-020 When cnt reaches LEN-1 issued, SHALL enter FLUSH and perform the final write; it SHALL then enter REL with busrq=0.
REQ-021 REL: SHALL wait for busak_n=1, then return to IDLE.
REQ-022 A dma_go edge while busy=1 SHALL set pending=1; further edges before IDLE SHALL NOT queue more than one.
REQ-023 If busak_n returns high during COPY or FLUSH, SHALL stall, hold cnt and suppress dst_we, and resume when busak_n=0 again.
REQ-024 dst_we SHALL be 0 whenever cen=0 or state is not COPY or FLUSH.
REQ-025 The counter SHALL be $clog2(LEN+1) bits wide; LEN=1 SHALL perform one read and one write.

Reset
REQ-026 rst=1 on a clk edge SHALL force IDLE, busrq=0, dst_we=0, busy=0, pending=0, cnt=0, src_addr=SRC_BASE, dst_addr=DST_BASE, dst_data=0, dst_bank=0, and the dma_go history to 0.
REQ-027 Reset asserted mid-transfer SHALL drop busrq on the same edge, independent of cen; no write SHALL occur in that cycle.

Configuration
REQ-028 With macro JTFRAME_OBJDMA_DBLBUF_EN defined, dst_bank SHALL toggle on the cen where REL is entered after a completed transfer, so the video side reads the finished bank.
REQ-029 Without JTFRAME_OBJDMA_DBLBUF_EN, dst_bank SHALL be constant 0 and no bank register SHALL exist.

Verification
REQ-030 LEN=4, SRC_BASE=0x100, src RAM holds addr[7:0]+1, cen always 1, busak_n follows busrq after 2 cycles -> writes 0x01,0x02,0x03,0x04 at DST_BASE..+3, busrq low 5 cycles after grant.
REQ-031 dma_go pulsed twice during a transfer -> exactly one further transfer follows; busy does not drop between them for more than the REL-to-IDLE-to-REQ gap.
REQ-032 busak_n released for 3 cen cycles mid-COPY -> no dst_we in those cycles; all LEN words are still written once, in order.
REQ-033 rst pulsed at word 2 of 4 -> busrq=0 and dst_we=0 on the next edge; a new dma_go then runs a full transfer from word 0.
REQ-034 SRC_BASE=2^AW-2, LEN=4 -> src_addr sequence wraps to 2^AW-2, 2^AW-1, 0, 1.
REQ-035 cen every 3rd clk, with DBLBUF macro on -> one write per cen, and dst_bank toggles 0->1->0 over two transfers; with the macro off, dst_bank stays 0.
